gsim_out_packer: RTL
====================

Name: gsim_out_packer

Overview:
- Downstream stage of the Gauss-Seidel solver core. Captures the 16-word Q16.16 solution burst the core emits on its out_valid/x_out pair.
- Converts each word to a rounded, saturated 16-bit integer and drains the vector to the consumer over a valid/ready handshake with index, last and saturation tags.
- Decouples the solver's free-running output phase from a backpressuring consumer.

Parameters:
N, 16, vector length (words per frame)
IN_W, 32, input word width, signed Q(IN_W-FRAC).FRAC
FRAC, 16, fractional bits in input word
OUT_W, 16, output integer width, signed

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  solver out_valid; high for at least N consecutive cycles per frame
in_data  in  IN_W  solver x_out, signed Q16.16, element index = capture order
out_valid  out  1  output word available
out_ready  in  1  consumer accepts word when out_valid&&out_ready
out_data  out  OUT_W  rounded/saturated element value
out_idx  out  4  element index 0..N-1 of out_data
out_last  out  1  high with element N-1
out_sat  out  1  out_data was clipped
busy  out  1  high in any state other than IDLE
frame_err  out  1  one-cycle pulse: burst ended short

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. On reset all outputs are 0, state = IDLE, wr_idx = rd_idx = 0, and buffer contents are don't-care. Reset mid-frame or mid-drain aborts immediately; no partial output follows.
- States:
  - IDLE: in_valid=1 writes in_data to buf[0], wr_idx<=1, go CAPTURE.
  - CAPTURE: in_valid=1 writes buf[wr_idx], wr_idx++. When word N-1 is written, go DRAIN. in_valid=0 before N words: frame_err=1 for one cycle, wr_idx<=0, go IDLE, nothing emitted.
  - DRAIN: out_valid=1 starting the cycle after entry. Latency is one cycle from the capture of word N-1 to out_valid with idx 0. in_valid/in_data are ignored.
  - WAIT_LOW: entered after the last handshake if in_valid=1. The solver holds out_valid high indefinitely and x_out wraps around, so re-capture is suppressed until in_valid=0, then go IDLE. If in_valid=0 at the last handshake, go IDLE directly.
- Handshake rules:
  - out_data/out_idx/out_last/out_sat are registered and must stay stable while out_valid=1 and out_ready=0.
  - Each handshake advances rd_idx. Back-to-back acceptance sustains 1 word per cycle.
  - out_valid drops the cycle after the handshake of idx N-1.
  - out_ready is ignored when out_valid=0.
- Conversion, per word w:
  - t = w + 2^(FRAC-1), computed at IN_W+1 bits so it cannot overflow.
  - r = t >>> FRAC (arithmetic shift).
  - If r > 2^(OUT_W-1)-1, out = 0x7FFF and sat=1. If r < -2^(OUT_W-1), out = 0x8000 and sat=1. Otherwise out = r[OUT_W-1:0] and sat=0.
  - Ties therefore round toward +inf (round-half-up).
- Capture order: word k of the burst is element k, with no reordering. in_valid high for more than N cycles is handled by WAIT_LOW. in_valid rising while in DRAIN is ignored.

Decomposition:
- Shared package gsim_pkg holds:
  - constants N=16, B_W=16, X_W=32, X_FRAC=16;
  - state encoding localparams ST_IDLE/ST_CAPTURE/ST_DRAIN/ST_WAIT_LOW;
  - index width IDX_W=4.
- One combinational sub-module q_round_sat (in IN_W, out OUT_W, sat flag) does rounding and saturation, placed between the buffer read mux and the output registers.

Test Plan:
- Nominal frame: 16 words with buf[k] = k<<16, out_ready=1, then in_valid held high for 40 more cycles. Expect out_data 0..15 on consecutive cycles, out_last only at idx 15, no second frame, busy drops after in_valid falls.
- Rounding: words 0x00018000, 0xFFFE8000, 0x00007FFF, 0xFFFF8000. Expect 2, 0xFFFF (-1), 0, 0; out_sat=0 for all.
- Saturation: words 0x7FFF8000 and 0x80000000. Expect 0x7FFF with sat=1, then 0x8000 with sat=0.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly. Expect out_data/out_idx held constant during stalls, exactly 16 handshakes, indices in order with none skipped or duplicated.
- Short burst: in_valid high for 9 cycles, then low. Expect a frame_err pulse one cycle, no out_valid, back in IDLE. A following full frame drains correctly.
- Reset mid-drain: assert reset at idx 6. Expect out_valid=0 next cycle and busy=0. A new frame then starts at idx 0.

Source files
------------

// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared constants and state encoding for the solver output packer
package gsim_pkg;

  localparam int N      = 16;  // words per solution frame
  localparam int B_W    = 16;  // packed output integer width
  localparam int X_W    = 32;  // solver word width, signed Q16.16
  localparam int X_FRAC = 16;  // fractional bits in a solver word
  localparam int IDX_W  = 4;   // element index width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

endpackage

// File: rtl/q_round_sat.sv
// rtl/q_round_sat.sv - round-half-up and saturate a signed fixed-point word to an integer
//   in_word  : signed fixed-point input, FRAC fractional bits
//   out_word : signed integer result, clipped to the OUT_W range
//   sat      : high when out_word was clipped
module q_round_sat #(
  parameter int IN_W  = 32,
  parameter int FRAC  = 16,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_word,
  output logic [OUT_W-1:0] out_word,
  output logic             sat
);

  // One extra bit of headroom so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] HALF =
    {{(IN_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  // Bitwise complement of the positive limit is exactly -2^(OUT_W-1).
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic signed [IN_W:0] t;
  logic signed [IN_W:0] r;

  always_comb begin
    t        = $signed({in_word[IN_W-1], in_word}) + HALF;
    r        = t >>> FRAC;
    out_word = r[OUT_W-1:0];
    sat      = 1'b0;
    if (r > MAXV) begin
      out_word = {1'b0, {(OUT_W-1){1'b1}}};
      sat      = 1'b1;
    end else if (r < MINV) begin
      out_word = {1'b1, {(OUT_W-1){1'b0}}};
      sat      = 1'b1;
    end
  end

endmodule

// File: rtl/gsim_out_packer.sv
// rtl/gsim_out_packer.sv - captures a solver frame and drains it as rounded 16-bit words
//   clk, reset          : clock and synchronous active-high reset
//   in_valid, in_data   : solver output burst, element index = capture order
//   out_valid/out_ready : consumer handshake
//   out_data            : rounded/saturated element value
//   out_idx, out_last   : element index, high with the final element
//   out_sat             : out_data was clipped
//   busy                : state is not IDLE
//   frame_err           : one-cycle pulse when a burst ends short
module gsim_out_packer #(
  parameter int N     = gsim_pkg::N,
  parameter int IN_W  = gsim_pkg::X_W,
  parameter int FRAC  = gsim_pkg::X_FRAC,
  parameter int OUT_W = gsim_pkg::B_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [gsim_pkg::IDX_W-1:0] out_idx,
  output logic                      out_last,
  output logic                      out_sat,
  output logic                      busy,
  output logic                      frame_err
);

  import gsim_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  state_t state_q, state_d;

  logic [IN_W-1:0]  frame_buf [N];
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] wr_addr;
  logic [IDX_W-1:0] rd_sel;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;
  logic             out_sat_q;
  logic             frame_err_q;

  logic             wr_en, wr_clr, load_first, pop, drain_done, short_err;
  logic [OUT_W-1:0] conv_data;
  logic             conv_sat;

  // The first word of a frame always lands in slot 0, whatever wr_idx holds.
  assign wr_addr = (state_q == ST_IDLE) ? '0 : wr_idx_q;

  // While a word is presented, look one slot ahead so the next word is ready
  // to be registered on the same edge as the handshake.
  assign rd_sel = out_valid_q ? (rd_idx_q + IDX_W'(1)) : rd_idx_q;

  q_round_sat #(
    .IN_W  (IN_W),
    .FRAC  (FRAC),
    .OUT_W (OUT_W)
  ) u_round (
    .in_word  (frame_buf[rd_sel]),
    .out_word (conv_data),
    .sat      (conv_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_clr     = 1'b0;
    load_first = 1'b0;
    pop        = 1'b0;
    drain_done = 1'b0;
    short_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) state_d = ST_DRAIN;
        end else begin
          short_err = 1'b1;
          wr_clr    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          load_first = 1'b1;
        end else if (out_ready) begin
          pop = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            drain_done = 1'b1;
            // The solver keeps out_valid high after a frame; block re-capture
            // of the wrapped-around words until it falls.
            state_d    = in_valid ? ST_WAIT_LOW : ST_IDLE;
          end
        end
      end
      ST_WAIT_LOW: begin
        if (!in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) frame_buf[wr_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= short_err;

      if (wr_en)       wr_idx_q <= wr_addr + IDX_W'(1);
      else if (wr_clr) wr_idx_q <= '0;

      if (load_first || (pop && !drain_done)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= conv_data;
        out_sat_q   <= conv_sat;
        out_idx_q   <= rd_sel;
        out_last_q  <= (rd_sel == LAST_IDX);
      end

      if (pop) begin
        if (drain_done) begin
          out_valid_q <= 1'b0;
          rd_idx_q    <= '0;
        end else begin
          rd_idx_q    <= rd_idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
